// File: rtl/addsub_serial_16bit_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit: state encoding,
// slice width and counter sizing.
package addsub_serial_16bit_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A single-nibble unit still needs a 1-bit counter.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/addsub_serial_16bit_nibble.sv
// Combinational 4-bit add/subtract slice; also exposes the carry into bit 3
// so the caller can form signed overflow on the final nibble.
module addsub_nibble
  import addsub_serial_16bit_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] b_x;
  logic [3:0]          low;
  logic [1:0]          high;

  always_comb begin
    b_x  = b ^ {NIBBLE_W{sub}};
    low  = {1'b0, a[2:0]} + {1'b0, b_x[2:0]} + {3'b000, cin};
    high = {1'b0, a[3]} + {1'b0, b_x[3]} + {1'b0, low[3]};
    s    = {high[0], low[2:0]};
    c3   = low[3];
    cout = high[1];
  end

endmodule

// File: rtl/addsub_serial_16bit.sv
// Nibble-serial signed add/subtract: one 4-bit slice processes the operands
// LSB nibble first, rippling the carry through a flop between cycles.
module addsub_serial_16bit
  import addsub_serial_16bit_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovfl
);

  localparam int            CW   = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovfl_q, ovfl_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_cout, nib_c3;

  assign nib_a = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];

  addsub_nibble u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .sub  (sub_q),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovfl_d  = ovfl_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q*NIBBLE_W +: NIBBLE_W] = nib_s;
        carry_d = nib_cout;
        cnt_d   = cnt_q + 1'b1;
        // The slice on the top nibble sees the real MSB carries.
        if (cnt_q == LAST) begin
          cout_d  = nib_cout;
          ovfl_d  = nib_cout ^ nib_c3;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovfl  = ovfl_q;

endmodule

// File: tb/tb_addsub_serial_16bit.sv
// Self-checking bench for addsub_serial_16bit: directed corner cases, abort by
// reset, and back-to-back random operations against an arithmetic model.
module tb_addsub_serial_16bit;

  logic        clk, rst, start, sub;
  logic [15:0] a, b;
  logic        ready, busy, done, cout, ovfl;
  logic [15:0] sum;

  int compared   = 0;
  int mismatched = 0;

  addsub_serial_16bit #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovfl  (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Two's-complement reference: {ovfl, cout, sum}.
  function automatic logic [17:0] refModel(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
    logic [16:0] full;
    logic        o;
    if (s) begin
      full = {1'b0, x} + {1'b0, ~y} + 17'd1;
      o    = (x[15] != y[15]) && (full[15] != x[15]);
    end else begin
      full = {1'b0, x} + {1'b0, y};
      o    = (x[15] == y[15]) && (full[15] != x[15]);
    end
    return {o, full[16], full[15:0]};
  endfunction

  // Called at a negedge while ready=1. Cycle 1 is the cycle start is presented.
  task automatic applyStimulus(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                               input logic is, input bit inject);
    logic [17:0] exp_v;
    int          lat;
    int          extra;
    exp_v = refModel(ia, ib, is);
    a = ia; b = ib; sub = is; start = 1'b1;
    lat = 0;
    for (int cyc = 2; cyc <= 20 && lat == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      if (inject && cyc == 3) begin
        start = 1'b1; a = 16'h0005; b = 16'h0003; sub = 1'b0;
      end
      if (done) lat = cyc;
    end
    checkOutput({tag, "_done_seen"}, 32'(lat != 0), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd6);
    checkOutput({tag, "_sum"}, 32'(sum), 32'(exp_v[15:0]));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(exp_v[16]));
    checkOutput({tag, "_ovfl"}, 32'(ovfl), 32'(exp_v[17]));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(ready), 32'd1);
    checkOutput({tag, "_sum_held"}, 32'(sum), 32'(exp_v[15:0]));
    if (inject) begin
      extra = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) extra++;
      end
      checkOutput({tag, "_no_extra_done"}, 32'(extra), 32'd0);
      checkOutput({tag, "_sum_kept"}, 32'(sum), 32'(exp_v[15:0]));
    end
  endtask

  initial begin
    logic [17:0] q_exp[$];
    logic [17:0] e;
    int          issued, finished, last_done, cyc, stray;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_ovfl", 32'(ovfl), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus("sub_zero", 16'h1234, 16'h1234, 1'b1, 1'b0);
    applyStimulus("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0);
    applyStimulus("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1);

    // Abort an operation with reset two cycles into RUN.
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    checkOutput("abort_ovfl", 32'(ovfl), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) stray++;
    end
    checkOutput("abort_no_done", 32'(stray), 32'd0);
    applyStimulus("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0);

    // Back-to-back random operations with start held high.
    issued = 0; finished = 0; last_done = -1; cyc = 0;
    start = 1'b1;
    while (finished < 200 && cyc < 2000) begin
      if (done) begin
        e = (q_exp.size() > 0) ? q_exp.pop_front() : 18'h3FFFF;
        checkOutput("rnd_sum", 32'(sum), 32'(e[15:0]));
        checkOutput("rnd_cout", 32'(cout), 32'(e[16]));
        checkOutput("rnd_ovfl", 32'(ovfl), 32'(e[17]));
        if (last_done >= 0) checkOutput("rnd_spacing", 32'(cyc - last_done), 32'd6);
        last_done = cyc;
        finished++;
      end
      checkOutput("rnd_onehot", 32'($countones({ready, busy, done})), 32'd1);
      if (ready && issued < 200) begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        q_exp.push_back(refModel(a, b, sub));
        issued++;
      end else begin
        if (issued >= 200) start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("rnd_completed", 32'(finished), 32'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
